// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for the ID stage.
// Counts in-flight writes per register and stalls issue on RAW or counter-saturation hazards.
module reg_scoreboard #(
  parameter int NUM_REGS      = 32,
  parameter int IDX_W         = 5,
  parameter int MAX_PEND      = 3,
  parameter int RETIRE_BYPASS = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        issue_valid,
  input  logic                                        issue_rs1_used,
  input  logic [IDX_W-1:0]                            issue_rs1,
  input  logic                                        issue_rs2_used,
  input  logic [IDX_W-1:0]                            issue_rs2,
  input  logic                                        issue_rd_wr,
  input  logic [IDX_W-1:0]                            issue_rd,
  output logic                                        stall,
  output logic                                        issue_fire,
  input  logic                                        retire_valid,
  input  logic [IDX_W-1:0]                            retire_rd,
  input  logic                                        kill_valid,
  input  logic [IDX_W-1:0]                            kill_rd,
  output logic [NUM_REGS-1:0]                         busy_vec,
  output logic [IDX_W+$clog2(MAX_PEND+1)-1:0]         inflight,
  output logic                                        underflow_err
);

  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam int SUM_W = IDX_W + CNT_W;

  logic [CNT_W-1:0]    cnt_r      [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt_s  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [SUM_W-1:0]    inflight_r;
  logic [SUM_W-1:0]    inflight_nxt_s;
  logic                underflow_r;
  logic                underflow_nxt_s;

  logic src1_hz_s;
  logic src2_hz_s;
  logic dst_hz_s;
  logic byp1_s;
  logic byp2_s;
  logic stall_s;
  logic fire_s;

  // Issue hazards: a retire of the last pending write may forward through the regfile
  always_comb begin
    byp1_s = (RETIRE_BYPASS != 0) && (cnt_r[issue_rs1] == CNT_W'(1)) &&
             retire_valid && (retire_rd == issue_rs1);
    byp2_s = (RETIRE_BYPASS != 0) && (cnt_r[issue_rs2] == CNT_W'(1)) &&
             retire_valid && (retire_rd == issue_rs2);
    src1_hz_s = issue_rs1_used && (issue_rs1 != IDX_W'(0)) &&
                (cnt_r[issue_rs1] != CNT_W'(0)) && !byp1_s;
    src2_hz_s = issue_rs2_used && (issue_rs2 != IDX_W'(0)) &&
                (cnt_r[issue_rs2] != CNT_W'(0)) && !byp2_s;
    dst_hz_s  = issue_rd_wr && (issue_rd != IDX_W'(0)) &&
                (cnt_r[issue_rd] == CNT_W'(MAX_PEND));
    stall_s   = issue_valid && (src1_hz_s || src2_hz_s || dst_hz_s);
    fire_s    = issue_valid && !stall_s;
  end

  // Next counter values; over-decrement clamps at zero and flags underflow
  always_comb begin
    logic             inc_v;
    logic             ret_v;
    logic             kil_v;
    logic [CNT_W+1:0] up_v;
    logic [CNT_W+1:0] dn_v;
    underflow_nxt_s = underflow_r;
    inflight_nxt_s  = SUM_W'(0);
    cnt_nxt_s[0]    = CNT_W'(0);
    busy_nxt_s      = {NUM_REGS{1'b0}};
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_v = fire_s && issue_rd_wr && (issue_rd == IDX_W'(r));
      ret_v = retire_valid && (retire_rd == IDX_W'(r));
      kil_v = kill_valid && (kill_rd == IDX_W'(r));
      up_v  = (CNT_W+2)'(cnt_r[r]) + (CNT_W+2)'(inc_v);
      dn_v  = (CNT_W+2)'(ret_v) + (CNT_W+2)'(kil_v);
      if (dn_v > up_v) begin
        cnt_nxt_s[r]    = CNT_W'(0);
        underflow_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s[r]    = CNT_W'(up_v - dn_v);
      end
      busy_nxt_s[r]  = (cnt_nxt_s[r] != CNT_W'(0));
      inflight_nxt_s = inflight_nxt_s + SUM_W'(cnt_nxt_s[r]);
    end
  end

  // State registers; reset discards every pending write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= CNT_W'(0);
      end
      busy_r      <= {NUM_REGS{1'b0}};
      inflight_r  <= SUM_W'(0);
      underflow_r <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
      busy_r      <= busy_nxt_s;
      inflight_r  <= inflight_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  assign stall         = stall_s;
  assign issue_fire    = fire_s;
  assign busy_vec      = busy_r;
  assign inflight      = inflight_r;
  assign underflow_err = underflow_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a per-register count model checked every cycle,
// plus hand-computed expectations at key points of the scenario.
module tb_reg_scoreboard;
  localparam int NR  = 32;
  localparam int IW  = 5;
  localparam int MP  = 3;
  localparam int BYP = 1;
  localparam int CW  = $clog2(MP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          issue_valid = 1'b0, issue_rs1_used = 1'b0, issue_rs2_used = 1'b0, issue_rd_wr = 1'b0;
  logic [IW-1:0] issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
  logic          retire_valid = 1'b0, kill_valid = 1'b0;
  logic [IW-1:0] retire_rd = '0, kill_rd = '0;
  logic          stall, issue_fire, underflow_err;
  logic [NR-1:0] busy_vec;
  logic [IW+CW-1:0] inflight;

  reg_scoreboard #(.NUM_REGS(NR), .IDX_W(IW), .MAX_PEND(MP), .RETIRE_BYPASS(BYP)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1_used(issue_rs1_used), .issue_rs1(issue_rs1),
    .issue_rs2_used(issue_rs2_used), .issue_rs2(issue_rs2),
    .issue_rd_wr(issue_rd_wr), .issue_rd(issue_rd),
    .stall(stall), .issue_fire(issue_fire),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .busy_vec(busy_vec), .inflight(inflight), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int mcnt[NR];
  bit muf    = 1'b0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit src_hz(input bit used, input int idx);
    if (!used || idx == 0 || mcnt[idx] == 0) return 1'b0;
    if (BYP != 0 && mcnt[idx] == 1 && retire_valid && int'(retire_rd) == idx) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    bit dst;
    dst = issue_rd_wr && issue_rd != 0 && mcnt[issue_rd] == MP;
    return issue_valid && (src_hz(issue_rs1_used, int'(issue_rs1)) ||
                           src_hz(issue_rs2_used, int'(issue_rs2)) || dst);
  endfunction

  // Reference model: each register's count of outstanding writes
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NR; r++) mcnt[r] = 0;
      muf = 1'b0;
    end else begin
      bit fire;
      fire = issue_valid && !m_stall();
      for (int r = 1; r < NR; r++) begin
        int n;
        n = mcnt[r];
        if (fire && issue_rd_wr && int'(issue_rd) == r) n++;
        if (retire_valid && int'(retire_rd) == r) n--;
        if (kill_valid && int'(kill_rd) == r) n--;
        if (n < 0) begin
          n = 0;
          muf = 1'b1;
        end
        mcnt[r] = n;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [NR-1:0] eb;
      int sum;
      eb = '0;
      sum = 0;
      for (int r = 1; r < NR; r++) begin
        eb[r] = (mcnt[r] != 0);
        sum += mcnt[r];
      end
      chk("stall", 64'(stall), 64'(m_stall()));
      chk("issue_fire", 64'(issue_fire), 64'(issue_valid && !m_stall()));
      chk("busy_vec", 64'(busy_vec), 64'(eb));
      chk("inflight", 64'(inflight), 64'(sum));
      chk("underflow_err", 64'(underflow_err), 64'(muf));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rs1_used = 1'b0; issue_rs2_used = 1'b0; issue_rd_wr = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    retire_valid = 1'b0; retire_rd = '0; kill_valid = 1'b0; kill_rd = '0;
  endtask

  task automatic iss(input bit u1, input int r1, input bit u2, input int r2, input bit wr, input int rd);
    issue_valid = 1'b1;
    issue_rs1_used = u1; issue_rs1 = IW'(r1);
    issue_rs2_used = u2; issue_rs2 = IW'(r2);
    issue_rd_wr = wr; issue_rd = IW'(rd);
  endtask

  task automatic ret(input int rd);
    retire_valid = 1'b1; retire_rd = IW'(rd);
  endtask

  task automatic kil(input int rd);
    kill_valid = 1'b1; kill_rd = IW'(rd);
  endtask

  initial begin
    idle();
    cmp_en = 1'b1;
    #2;
    chk("rst busy", 64'(busy_vec), 64'd0);
    chk("rst inflight", 64'(inflight), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();

    // Issue rd=5, then RAW on rs1=5 resolved by same-cycle retire
    iss(1'b1, 0, 1'b0, 0, 1'b1, 5); #1;
    chk("fire rd5", 64'(issue_fire), 64'd1);
    cyc(); idle(); #1;
    chk("busy5", 64'(busy_vec[5]), 64'd1);
    chk("inflight1", 64'(inflight), 64'd1);
    iss(1'b1, 5, 1'b0, 0, 1'b0, 0); #1;
    chk("raw stall", 64'(stall), 64'd1);
    cyc(); #1;
    chk("raw stall hold", 64'(stall), 64'd1);
    ret(5); #1;
    chk("bypass stall", 64'(stall), 64'd0);
    cyc(); idle(); #1;
    chk("inflight0", 64'(inflight), 64'd0);

    // Saturate r7; retire does not relieve the destination hazard
    repeat (3) begin iss(1'b0, 0, 1'b0, 0, 1'b1, 7); cyc(); end
    chk("sat inflight", 64'(inflight), 64'd3);
    ret(7); #1;
    chk("sat stall", 64'(stall), 64'd1);
    cyc(); idle(); #1;
    chk("sat cnt2", 64'(inflight), 64'd2);
    iss(1'b0, 0, 1'b0, 0, 1'b1, 7); #1;
    chk("fifth fire", 64'(issue_fire), 64'd1);
    cyc(); idle(); #1;
    chk("cnt3", 64'(inflight), 64'd3);
    repeat (3) begin ret(7); cyc(); end
    idle();

    // Issue, retire and kill of r9 in one cycle
    repeat (2) begin iss(1'b0, 0, 1'b0, 0, 1'b1, 9); cyc(); end
    iss(1'b0, 0, 1'b0, 0, 1'b1, 9); ret(9); kil(9); #1;
    chk("triple fire", 64'(issue_fire), 64'd1);
    cyc(); idle(); #1;
    chk("triple inflight", 64'(inflight), 64'd1);
    chk("triple no err", 64'(underflow_err), 64'd0);
    ret(9); cyc(); idle();

    // rs2 field ignored when unused
    iss(1'b0, 0, 1'b0, 0, 1'b1, 4); cyc();
    iss(1'b1, 3, 1'b0, 4, 1'b0, 0); #1;
    chk("rs2 unused", 64'(stall), 64'd0);
    issue_rs2_used = 1'b1; #1;
    chk("rs2 used", 64'(stall), 64'd1);
    cyc(); idle(); ret(4); cyc(); idle();

    // r0 retire is ignored; r12 retire underflows and sticks
    ret(0); cyc(); idle(); #1;
    chk("r0 no err", 64'(underflow_err), 64'd0);
    ret(12); cyc(); idle(); #1;
    chk("uf set", 64'(underflow_err), 64'd1);
    cyc(); #1;
    chk("uf sticky", 64'(underflow_err), 64'd1);
    chk("uf busy", 64'(busy_vec), 64'd0);

    // Asynchronous reset mid-stream
    repeat (2) begin iss(1'b0, 0, 1'b0, 0, 1'b1, 5); cyc(); end
    idle(); #1;
    chk("pre rst inflight", 64'(inflight), 64'd2);
    rst = 1'b0; #1;
    chk("async busy", 64'(busy_vec), 64'd0);
    chk("async inflight", 64'(inflight), 64'd0);
    chk("async uf", 64'(underflow_err), 64'd0);
    cyc(); rst = 1'b1; cyc();
    iss(1'b1, 5, 1'b0, 0, 1'b0, 0); #1;
    chk("post rst stall", 64'(stall), 64'd0);
    cyc(); idle();

    // Kill after reset underflows; kill and non-final retire never bypass
    kil(5); cyc(); idle(); #1;
    chk("kill uf", 64'(underflow_err), 64'd1);
    iss(1'b0, 0, 1'b0, 0, 1'b1, 3); cyc();
    iss(1'b1, 3, 1'b0, 0, 1'b0, 0); kil(3); #1;
    chk("kill no bypass", 64'(stall), 64'd1);
    cyc(); idle(); #1;
    chk("kill cleared", 64'(inflight), 64'd0);
    repeat (2) begin iss(1'b0, 0, 1'b0, 0, 1'b1, 3); cyc(); end
    iss(1'b1, 3, 1'b0, 0, 1'b0, 0); ret(3); #1;
    chk("cnt2 no bypass", 64'(stall), 64'd1);
    cyc(); idle(); #1;
    chk("cnt2 after ret", 64'(inflight), 64'd1);
    repeat (2) cyc();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
